uart_tx: RTL and testbench

- Serial UART transmitter: serialises one byte per request as 1 start bit, DATA_BITS data bits (LSB first) and a stop period, timed by an external oversampled baud tick.
- Counterpart of uart_rx; shares the same `tick` source, so a tx→rx loopback runs at one baud configuration.
- Sits between a byte producer (CPU/FIFO) and the `tx` pin.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_tx.sv | 84 ++++++++
 tb/tb_uart_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default frame constants shared by uart_tx and uart_rx
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_SB_TICK    = 16;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: serialises one frame per accepted request, timed by an external oversampled baud tick
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int SB_TICK    = UART_SB_TICK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);
    localparam int MAXT = OVERSAMPLE > SB_TICK ? OVERSAMPLE : SB_TICK;
    localparam int CW = MAXT > 1 ? $clog2(MAXT) : 1;
    localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] OS_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SB_LAST  = CW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        idx;
    logic [DATA_BITS-1:0] sh;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            sh           <= '0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        sh      <= din;
                        cnt     <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: if (tick) begin
                    if (cnt == OS_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        tx    <= sh[0];
                        state <= DATA;
                    end else cnt <= cnt + 1'b1;
                end
                DATA: if (tick) begin
                    if (cnt == OS_LAST) begin
                        cnt <= '0;
                        sh  <= sh >> 1;
                        // tx leads the shift so the next bit appears on the boundary edge
                        if (idx == BIT_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx  <= sh[1];
                            idx <= idx + 1'b1;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                STOP: if (tick) begin
                    if (cnt == SB_LAST) begin
                        cnt          <= '0;
                        tx_busy      <= 1'b0;
                        tx_done_tick <= 1'b1;
                        state        <= IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomised frames checked against a tick-count model of the line
module tb_uart_tx;
    localparam int DB = 8;
    localparam int OS = 16;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx dut_a (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start_a), .din(din),
        .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a)
    );
    uart_tx #(.SB_TICK(32)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start_b), .din(din),
        .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] obs(input bit sel);
        return sel ? {tx_b, busy_b, done_b} : {tx_a, busy_a, done_a};
    endfunction

    task automatic check(input string tag, input logic [2:0] o, input logic [2:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed {tx,busy,done}=%b expected %b", tag, o, e);
        end
    endtask

    // Line level after n counted ticks: start bit, data bits LSB first, then stop level.
    function automatic logic exp_line(input logic [7:0] d, input int n);
        int b = n / OS;
        return b == 0 ? 1'b0 : b <= DB ? d[b-1] : 1'b1;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    // Sends one frame; inj = tick count at which a stray request is raised, abort = tick count for reset.
    task automatic frame(input bit sel, input logic [7:0] d, input int p, input int inj, input int abort);
        int sb = sel ? 32 : 16;
        int total = (1 + DB) * OS + sb;
        int n = 0;
        din = d;
        tick = 1'b1;
        set_start(sel, 1'b1);
        step();
        set_start(sel, 1'b0);
        din = 8'($urandom);
        check("accept", obs(sel), 3'b010);
        for (int k = 1; k <= total * p + 8; k++) begin
            tick = (k % p) == 0;
            if (n == inj) begin
                din = 8'hFF;
                set_start(sel, 1'b1);
            end else set_start(sel, 1'b0);
            if (abort >= 0 && n == abort) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                tick = 1'b0;
                check("abort", obs(sel), 3'b100);
                return;
            end
            step();
            if (tick) n++;
            if (n == total) begin
                set_start(sel, 1'b0);
                check("done", obs(sel), 3'b101);
                return;
            end
            check("bit", obs(sel), {exp_line(d, n), 2'b10});
        end
        set_start(sel, 1'b0);
        checks++;
        errors++;
        $error("FAIL timeout: no done after %0d ticks, observed %b", n, obs(sel));
    endtask

    task automatic idle(input int c, input bit sel);
        for (int i = 0; i < c; i++) begin
            tick = 1'($urandom_range(0, 1));
            step();
            check("idle", obs(sel), 3'b100);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            tick = ~tick;
            step();
        end
        check("reset_a", obs(0), 3'b100);
        check("reset_b", obs(1), 3'b100);
        rst = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            check("quiet", obs(0), 3'b100);
        end
        frame(0, 8'h55, 1, -1, -1);
        idle(5, 0);
        frame(0, 8'hA3, 4, 40, -1);
        idle(12, 0);
        frame(0, 8'h0F, 1, -1, -1);
        frame(0, 8'hF0, 1, -1, -1);
        idle(4, 0);
        frame(0, 8'h00, 1, -1, 70);
        idle(20, 0);
        frame(0, 8'h81, 2, -1, -1);
        idle(3, 0);
        frame(1, 8'hC3, 1, -1, -1);
        idle(3, 1);
        for (int r = 0; r < 6; r++) begin
            bit sel = 1'($urandom_range(0, 1));
            frame(sel, 8'($urandom), int'($urandom_range(1, 4)), -1, -1);
            idle(int'($urandom_range(0, 3)), sel);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
